// File: rtl/dm.sv
// Shared definitions for the debug module: DMI register map, field layouts and enums.
package dm;

    localparam int unsigned DMI_AW = 7;
    localparam int unsigned XLEN   = 32;
    localparam int unsigned GPR_AW = 5;

    localparam logic [DMI_AW-1:0] DATA0      = 7'h04;
    localparam logic [DMI_AW-1:0] DMCONTROL  = 7'h10;
    localparam logic [DMI_AW-1:0] DMSTATUS   = 7'h11;
    localparam logic [DMI_AW-1:0] HARTINFO   = 7'h12;
    localparam logic [DMI_AW-1:0] ABSTRACTCS = 7'h16;
    localparam logic [DMI_AW-1:0] COMMAND    = 7'h17;

    localparam logic [15:0] GPR_BASE = 16'h1000;

    typedef enum logic [2:0] {
        NONE       = 3'd0,
        BUSY       = 3'd1,
        NOTSUP     = 3'd2,
        EXCEPTION  = 3'd3,
        HALTRESUME = 3'd4
    } cmderr_e;

    typedef enum logic [1:0] {
        DMI_NOP   = 2'd0,
        DMI_READ  = 2'd1,
        DMI_WRITE = 2'd2,
        DMI_RSVD  = 2'd3
    } dmi_op_e;

    typedef enum logic [1:0] {
        A_IDLE = 2'd0,
        A_REQ  = 2'd1,
        A_DONE = 2'd2
    } abs_state_e;

    typedef struct packed {
        logic        haltreq;
        logic        resumereq;
        logic [27:0] zero0;
        logic        ndmreset;
        logic        dmactive;
    } dmcontrol_t;

    typedef struct packed {
        logic [13:0] zero0;
        logic        allresumeack;
        logic        anyresumeack;
        logic [3:0]  zero1;
        logic        allrunning;
        logic        anyrunning;
        logic        allhalted;
        logic        anyhalted;
        logic        authenticated;
        logic [2:0]  zero2;
        logic [3:0]  version;
    } dmstatus_t;

    typedef struct packed {
        logic [2:0]  zero0;
        logic [4:0]  progbufsize;
        logic [10:0] zero1;
        logic        busy;
        logic        zero2;
        cmderr_e     cmderr;
        logic [3:0]  zero3;
        logic [3:0]  datacount;
    } abstractcs_t;

    typedef struct packed {
        logic [7:0]  cmdtype;
        logic        rsvd;
        logic [2:0]  aarsize;
        logic        aarpostincrement;
        logic        postexec;
        logic        transfer;
        logic        write;
        logic [15:0] regno;
    } command_t;

endpackage

// File: rtl/dm_abstract_cmd.sv
// Abstract "access register" sequencer: drives the GPR request/ack handshake into the hart.
module dm_abstract_cmd
    import dm::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              write,
    input  logic [GPR_AW-1:0] regno,
    input  logic [XLEN-1:0]   data0_in,
    input  logic              dmactive,
    output logic              reg_req,
    output logic              reg_we,
    output logic [GPR_AW-1:0] reg_addr,
    output logic [XLEN-1:0]   reg_wdata,
    input  logic [XLEN-1:0]   reg_rdata,
    input  logic              reg_ack,
    output logic              busy,
    output logic              data0_wr,
    output logic [XLEN-1:0]   data0_wdata
);

    abs_state_e        state_q, state_d;
    logic              req_d, we_d;
    logic [GPR_AW-1:0] addr_d;
    logic [XLEN-1:0]   wdata_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= A_IDLE;
            reg_req   <= 1'b0;
            reg_we    <= 1'b0;
            reg_addr  <= '0;
            reg_wdata <= '0;
        end else begin
            state_q   <= state_d;
            reg_req   <= req_d;
            reg_we    <= we_d;
            reg_addr  <= addr_d;
            reg_wdata <= wdata_d;
        end
    end

    // A deactivated DM still waits for the ack, then drops the read data.
    always_comb begin
        state_d  = state_q;
        req_d    = reg_req;
        we_d     = reg_we;
        addr_d   = reg_addr;
        wdata_d  = reg_wdata;
        data0_wr = 1'b0;
        case (state_q)
            A_IDLE: begin
                if (start) begin
                    state_d = A_REQ;
                    req_d   = 1'b1;
                    we_d    = write;
                    addr_d  = regno;
                    wdata_d = data0_in;
                end
            end
            A_REQ: begin
                if (reg_ack) begin
                    state_d  = dmactive ? A_DONE : A_IDLE;
                    req_d    = 1'b0;
                    we_d     = 1'b0;
                    addr_d   = '0;
                    wdata_d  = '0;
                    data0_wr = dmactive && !reg_we;
                end
            end
            A_DONE:  state_d = A_IDLE;
            default: state_d = A_IDLE;
        endcase
    end

    assign busy        = (state_q != A_IDLE);
    assign data0_wdata = reg_rdata;

endmodule

// File: rtl/debug_module.sv
// Debug Module register core for a single hart: DMI register file, run control and abstract commands.
module debug_module
    import dm::*;
#(
    parameter int unsigned IDLE_TIMEOUT = 0,
    parameter int unsigned NUM_GPR      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dmi_start,
    input  logic [1:0]        dmi_op,
    input  logic [DMI_AW-1:0] dmi_address,
    input  logic [XLEN-1:0]   dmi_wdata,
    output logic [XLEN-1:0]   dmi_rdata,
    output logic              dmi_finish,
    output logic              halt_req,
    output logic              resume_req,
    input  logic              hart_halted,
    input  logic              hart_running,
    output logic              ndmreset,
    output logic              reg_req,
    output logic              reg_we,
    output logic [GPR_AW-1:0] reg_addr,
    output logic [XLEN-1:0]   reg_wdata,
    input  logic [XLEN-1:0]   reg_rdata,
    input  logic              reg_ack
);

    logic            dmactive, resume_pending, resumeack;
    cmderr_e         cmderr, cmd_err_next;
    logic [XLEN-1:0] data0, rd_val, data0_wdata;
    logic            busy, data0_wr, cmd_go, cmd_start;
    logic            accept, is_read, is_write, regno_ok;
    dmcontrol_t      ctl_w, ctl_r;
    dmstatus_t       sts_r;
    abstractcs_t     acs_r;
    command_t        cmd;
    logic            unused_bits;

    assign accept    = dmi_start && !dmi_finish;
    assign is_read   = accept && (dmi_op == DMI_READ);
    assign is_write  = accept && (dmi_op == DMI_WRITE);
    assign ctl_w     = dmcontrol_t'(dmi_wdata);
    assign cmd       = command_t'(dmi_wdata);
    assign regno_ok  = (cmd.regno >= GPR_BASE) && (cmd.regno < GPR_BASE + 16'(NUM_GPR));
    assign cmd_start = is_write && (dmi_address == COMMAND) && dmactive && cmd_go;
    assign resume_req = resume_pending;

    // IDLE_TIMEOUT is reserved; no ack timeout exists.
    assign unused_bits = ^{ctl_w.zero0, cmd.rsvd, cmd.aarpostincrement, cmd.postexec,
                           1'(IDLE_TIMEOUT != 0)};

    // Command acceptance checks, highest priority first.
    always_comb begin
        cmd_err_next = cmderr;
        cmd_go       = 1'b0;
        if (busy) begin
            cmd_err_next = BUSY;
        end else if (cmderr == NONE) begin
            if (cmd.cmdtype != 8'd0 || cmd.aarsize != 3'd2 || (cmd.transfer && !regno_ok))
                cmd_err_next = NOTSUP;
            else if (!hart_halted)
                cmd_err_next = HALTRESUME;
            else
                cmd_go = cmd.transfer;
        end
    end

    always_comb begin
        ctl_r                = '0;
        ctl_r.haltreq        = halt_req;
        ctl_r.ndmreset       = ndmreset;
        ctl_r.dmactive       = dmactive;
        sts_r                = '0;
        sts_r.version        = 4'd2;
        sts_r.authenticated  = 1'b1;
        sts_r.anyhalted      = hart_halted;
        sts_r.allhalted      = hart_halted;
        sts_r.anyrunning     = hart_running;
        sts_r.allrunning     = hart_running;
        sts_r.anyresumeack   = resumeack;
        sts_r.allresumeack   = resumeack;
        acs_r                = '0;
        acs_r.datacount      = 4'd1;
        acs_r.busy           = busy;
        acs_r.cmderr         = cmderr;
        rd_val               = '0;
        case (dmi_address)
            DATA0:      rd_val = data0;
            DMCONTROL:  rd_val = ctl_r;
            DMSTATUS:   rd_val = sts_r;
            ABSTRACTCS: rd_val = acs_r;
            default:    rd_val = '0;
        endcase
    end

    // A write that leaves dmactive=1 takes effect in full, even when it is the activating write.
    always_ff @(posedge clk) begin
        if (rst) begin
            dmi_finish     <= 1'b0;
            dmi_rdata      <= '0;
            dmactive       <= 1'b0;
            halt_req       <= 1'b0;
            ndmreset       <= 1'b0;
            resume_pending <= 1'b0;
            resumeack      <= 1'b0;
            cmderr         <= NONE;
            data0          <= '0;
        end else begin
            dmi_finish <= accept;
            if (accept)
                dmi_rdata <= is_read ? rd_val : '0;
            if (resume_pending && hart_running) begin
                resume_pending <= 1'b0;
                resumeack      <= 1'b1;
            end
            if (data0_wr)
                data0 <= data0_wdata;
            if (is_write) begin
                case (dmi_address)
                    DMCONTROL: begin
                        dmactive <= ctl_w.dmactive;
                        if (!ctl_w.dmactive) begin
                            halt_req       <= 1'b0;
                            ndmreset       <= 1'b0;
                            resume_pending <= 1'b0;
                            resumeack      <= 1'b0;
                            cmderr         <= NONE;
                            data0          <= '0;
                        end else begin
                            halt_req <= ctl_w.haltreq;
                            ndmreset <= ctl_w.ndmreset;
                            if (ctl_w.resumereq && !ctl_w.haltreq) begin
                                resume_pending <= 1'b1;
                                resumeack      <= 1'b0;
                            end
                        end
                    end
                    DATA0: begin
                        if (dmactive) begin
                            if (!busy)
                                data0 <= dmi_wdata;
                            else if (cmderr == NONE)
                                cmderr <= BUSY;
                        end
                    end
                    ABSTRACTCS: begin
                        if (dmactive)
                            cmderr <= cmderr_e'(cmderr & ~dmi_wdata[10:8]);
                    end
                    COMMAND: begin
                        if (dmactive)
                            cmderr <= cmd_err_next;
                    end
                    default: ;
                endcase
            end
        end
    end

    dm_abstract_cmd u_abstract_cmd (
        .clk         (clk),
        .rst         (rst),
        .start       (cmd_start),
        .write       (cmd.write),
        .regno       (cmd.regno[GPR_AW-1:0]),
        .data0_in    (data0),
        .dmactive    (dmactive),
        .reg_req     (reg_req),
        .reg_we      (reg_we),
        .reg_addr    (reg_addr),
        .reg_wdata   (reg_wdata),
        .reg_rdata   (reg_rdata),
        .reg_ack     (reg_ack),
        .busy        (busy),
        .data0_wr    (data0_wr),
        .data0_wdata (data0_wdata)
    );

endmodule

// File: tb/tb_debug_module.sv
// Directed self-checking bench for debug_module: DMI register access, run control and abstract commands.
module tb_debug_module;
    import dm::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        dmi_start;
    logic [1:0]  dmi_op;
    logic [6:0]  dmi_address;
    logic [31:0] dmi_wdata;
    logic [31:0] dmi_rdata;
    logic        dmi_finish;
    logic        halt_req, resume_req, ndmreset;
    logic        hart_halted, hart_running;
    logic        reg_req, reg_we;
    logic [4:0]  reg_addr;
    logic [31:0] reg_wdata, reg_rdata;
    logic        reg_ack;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    debug_module #(.IDLE_TIMEOUT(0), .NUM_GPR(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .dmi_start    (dmi_start),
        .dmi_op       (dmi_op),
        .dmi_address  (dmi_address),
        .dmi_wdata    (dmi_wdata),
        .dmi_rdata    (dmi_rdata),
        .dmi_finish   (dmi_finish),
        .halt_req     (halt_req),
        .resume_req   (resume_req),
        .hart_halted  (hart_halted),
        .hart_running (hart_running),
        .ndmreset     (ndmreset),
        .reg_req      (reg_req),
        .reg_we       (reg_we),
        .reg_addr     (reg_addr),
        .reg_wdata    (reg_wdata),
        .reg_rdata    (reg_rdata),
        .reg_ack      (reg_ack)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Called just after an active edge; leaves one idle cycle so dmi_finish has cleared.
    task automatic dmi_txn(input logic [1:0] op, input logic [6:0] addr, input logic [31:0] wdata,
                           output logic [31:0] rdata);
        dmi_start   = 1'b1;
        dmi_op      = op;
        dmi_address = addr;
        dmi_wdata   = wdata;
        @(posedge clk); #1;
        dmi_start = 1'b0;
        dmi_op    = 2'd0;
        check("dmi_finish", 32'(dmi_finish), 32'd1);
        rdata = dmi_rdata;
        @(posedge clk); #1;
    endtask

    task automatic dmi_wr(input logic [6:0] addr, input logic [31:0] wdata);
        logic [31:0] r;
        dmi_txn(2'd2, addr, wdata, r);
        check("wr_rdata_zero", r, 32'd0);
    endtask

    task automatic dmi_rd(input string tag, input logic [6:0] addr, input logic [31:0] exp);
        logic [31:0] r;
        dmi_txn(2'd1, addr, 32'd0, r);
        check(tag, r, exp);
    endtask

    task automatic ack_pulse(input logic [31:0] rdata);
        reg_rdata = rdata;
        reg_ack   = 1'b1;
        @(posedge clk); #1;
        reg_ack   = 1'b0;
        reg_rdata = 32'd0;
        check("reg_req_after_ack", 32'(reg_req), 32'd0);
    endtask

    initial begin
        logic [31:0] r;
        rst = 1'b1; dmi_start = 1'b0; dmi_op = 2'd0; dmi_address = 7'd0; dmi_wdata = 32'd0;
        hart_halted = 1'b0; hart_running = 1'b0; reg_rdata = 32'd0; reg_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_halt_req", 32'(halt_req), 32'd0);
        check("rst_resume_req", 32'(resume_req), 32'd0);
        check("rst_ndmreset", 32'(ndmreset), 32'd0);
        check("rst_reg_req", 32'(reg_req), 32'd0);
        check("rst_dmi_finish", 32'(dmi_finish), 32'd0);
        check("rst_dmi_rdata", dmi_rdata, 32'd0);
        rst = 1'b0;

        dmi_rd("dmstatus_idle", DMSTATUS, 32'h0000_0082);
        dmi_rd("abstractcs_rst", ABSTRACTCS, 32'h0000_0001);
        dmi_rd("dmcontrol_rst", DMCONTROL, 32'h0000_0000);
        dmi_wr(DATA0, 32'h5555_5555);
        dmi_rd("data0_inactive", DATA0, 32'h0000_0000);

        dmi_wr(DMCONTROL, 32'h8000_0001);
        check("halt_req_set", 32'(halt_req), 32'd1);
        dmi_rd("dmcontrol_rb", DMCONTROL, 32'h8000_0001);
        hart_halted = 1'b1;
        dmi_rd("dmstatus_halted", DMSTATUS, 32'h0000_0382);

        dmi_txn(2'd0, DMSTATUS, 32'd0, r);
        check("nop_rdata", r, 32'd0);
        dmi_rd("unmapped", 7'h20, 32'd0);
        dmi_rd("hartinfo", HARTINFO, 32'd0);
        dmi_rd("command_reads_zero", COMMAND, 32'd0);

        // start held while finish is pending: second beat must be dropped
        dmi_start = 1'b1; dmi_op = 2'd2; dmi_address = DATA0; dmi_wdata = 32'h1;
        @(posedge clk); #1;
        check("pend_first_finish", 32'(dmi_finish), 32'd1);
        dmi_wdata = 32'h2;
        @(posedge clk); #1;
        dmi_start = 1'b0; dmi_op = 2'd0;
        check("pend_second_finish", 32'(dmi_finish), 32'd0);
        dmi_rd("data0_pending", DATA0, 32'h1);

        // GPR write x5
        dmi_wr(DATA0, 32'hDEAD_BEEF);
        dmi_wr(COMMAND, 32'h0023_1005);
        check("wr_reg_req", 32'(reg_req), 32'd1);
        check("wr_reg_we", 32'(reg_we), 32'd1);
        check("wr_reg_addr", 32'(reg_addr), 32'd5);
        check("wr_reg_wdata", reg_wdata, 32'hDEAD_BEEF);
        dmi_rd("abstractcs_busy", ABSTRACTCS, 32'h0000_1001);
        ack_pulse(32'hFFFF_FFFF);
        dmi_rd("abstractcs_done", ABSTRACTCS, 32'h0000_1001);
        dmi_rd("abstractcs_idle", ABSTRACTCS, 32'h0000_0001);
        dmi_rd("data0_after_wr", DATA0, 32'hDEAD_BEEF);

        // GPR read x3
        dmi_wr(COMMAND, 32'h0022_1003);
        check("rd_reg_we", 32'(reg_we), 32'd0);
        check("rd_reg_addr", 32'(reg_addr), 32'd3);
        ack_pulse(32'h1234_5678);
        @(posedge clk); #1;
        dmi_rd("data0_gpr_rd", DATA0, 32'h1234_5678);
        dmi_rd("abstractcs_ok", ABSTRACTCS, 32'h0000_0001);

        // busy errors
        dmi_wr(COMMAND, 32'h0023_1006);
        check("busy_reg_wdata", reg_wdata, 32'h1234_5678);
        dmi_wr(COMMAND, 32'h0023_1007);
        check("busy_reg_addr", 32'(reg_addr), 32'd6);
        dmi_rd("cmderr_busy_cmd", ABSTRACTCS, 32'h0000_1101);
        dmi_wr(ABSTRACTCS, 32'h0000_0100);
        dmi_rd("cmderr_w1c_busy", ABSTRACTCS, 32'h0000_1001);
        dmi_wr(DATA0, 32'h1111_1111);
        dmi_rd("cmderr_busy_data0", ABSTRACTCS, 32'h0000_1101);
        ack_pulse(32'hA5A5_A5A5);
        @(posedge clk); #1;
        dmi_rd("data0_busy_ignored", DATA0, 32'h1234_5678);
        dmi_wr(COMMAND, 32'h0023_1005);
        check("cmd_ignored_req", 32'(reg_req), 32'd0);
        dmi_rd("cmderr_sticky", ABSTRACTCS, 32'h0000_0101);
        dmi_wr(ABSTRACTCS, 32'h0000_0700);
        dmi_rd("cmderr_clear", ABSTRACTCS, 32'h0000_0001);

        // unsupported commands
        dmi_wr(COMMAND, 32'h0032_1005);
        check("aarsize_no_req", 32'(reg_req), 32'd0);
        dmi_rd("cmderr_aarsize", ABSTRACTCS, 32'h0000_0201);
        dmi_wr(ABSTRACTCS, 32'h0000_0200);
        dmi_wr(COMMAND, 32'h0022_1020);
        dmi_rd("cmderr_regno", ABSTRACTCS, 32'h0000_0201);
        dmi_wr(ABSTRACTCS, 32'h0000_0700);
        dmi_wr(COMMAND, 32'h0122_1005);
        dmi_rd("cmderr_cmdtype", ABSTRACTCS, 32'h0000_0201);
        dmi_wr(ABSTRACTCS, 32'h0000_0700);
        dmi_wr(COMMAND, 32'h0020_1020);
        check("notransfer_no_req", 32'(reg_req), 32'd0);
        dmi_rd("notransfer_ok", ABSTRACTCS, 32'h0000_0001);

        // hart not halted
        hart_halted = 1'b0; hart_running = 1'b1;
        dmi_wr(COMMAND, 32'h0022_1001);
        check("haltresume_no_req", 32'(reg_req), 32'd0);
        dmi_rd("cmderr_haltresume", ABSTRACTCS, 32'h0000_0401);
        dmi_wr(ABSTRACTCS, 32'h0000_0700);

        // resume control
        hart_running = 1'b0;
        dmi_wr(DMCONTROL, 32'hC000_0001);
        check("resume_blocked", 32'(resume_req), 32'd0);
        check("halt_kept", 32'(halt_req), 32'd1);
        dmi_wr(DMCONTROL, 32'h4000_0001);
        check("resume_req_set", 32'(resume_req), 32'd1);
        check("halt_req_clr", 32'(halt_req), 32'd0);
        dmi_rd("dmstatus_resuming", DMSTATUS, 32'h0000_0082);
        hart_running = 1'b1;
        @(posedge clk); #1;
        check("resume_req_fall", 32'(resume_req), 32'd0);
        dmi_rd("dmstatus_resumeack", DMSTATUS, 32'h0003_0C82);

        // ndmreset and deactivation
        dmi_wr(DMCONTROL, 32'h0000_0003);
        check("ndmreset_set", 32'(ndmreset), 32'd1);
        dmi_rd("dmcontrol_ndm", DMCONTROL, 32'h0000_0003);
        dmi_wr(DMCONTROL, 32'h0000_0000);
        check("ndmreset_clr", 32'(ndmreset), 32'd0);
        dmi_rd("dmstatus_inactive", DMSTATUS, 32'h0000_0C82);
        dmi_rd("data0_cleared", DATA0, 32'h0000_0000);

        // deactivate mid-request: handshake completes, read data discarded
        hart_running = 1'b0; hart_halted = 1'b1;
        dmi_wr(DMCONTROL, 32'h0000_0001);
        dmi_wr(COMMAND, 32'h0022_1007);
        check("abort_req", 32'(reg_req), 32'd1);
        dmi_wr(DMCONTROL, 32'h0000_0000);
        check("abort_req_held", 32'(reg_req), 32'd1);
        ack_pulse(32'hCAFE_F00D);
        dmi_wr(DMCONTROL, 32'h0000_0001);
        dmi_rd("data0_abort", DATA0, 32'h0000_0000);
        dmi_rd("abstractcs_abort", ABSTRACTCS, 32'h0000_0001);

        // reset during a request
        dmi_wr(COMMAND, 32'h0022_1002);
        check("rst_mid_req_before", 32'(reg_req), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_req_drop", 32'(reg_req), 32'd0);
        rst = 1'b0;
        dmi_rd("abstractcs_post_rst", ABSTRACTCS, 32'h0000_0001);
        dmi_rd("dmcontrol_post_rst", DMCONTROL, 32'h0000_0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
